// File: rtl/multdiv_stage.sv
// Iterative multiply/divide unit for the execute stage.
// Multiply: unsigned shift-add on operand magnitudes, one multiplier bit per RUN cycle.
// Divide: restoring division on magnitudes, one quotient bit per RUN cycle.
// The result sign is applied once, on the edge that completes the last iteration.
module multdiv_stage #(
    parameter int unsigned ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_mult,
    input  logic        in_is_div,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_ir,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_exception,
    output logic [31:0] out_ir,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [5:0] LastCnt = 6'(ITER - 1);

    state_e      state_q;
    logic [31:0] a_mag_q;   // multiplicand magnitude
    logic [31:0] b_mag_q;   // divisor magnitude
    logic        sign_q;
    logic        mult_q;
    logic [31:0] ir_q;
    logic [5:0]  cnt_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half shifts dividend bits out and quotient bits in.
    logic [63:0] acc_q;
    logic [32:0] rem_q;

    logic        accept;
    logic        div_zero;
    logic        last_iter;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] prod;
    logic        mul_exc;
    logic [33:0] rem_wide;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_signed;
    logic        div_exc;

    assign in_ready = (state_q == StIdle);

    // Accept decode, operand magnitudes and one iteration of each datapath.
    always_comb begin
        accept     = in_valid & in_ready & (in_is_mult | in_is_div);
        // Multiply wins when both op bits are set, so only a pure divide can trap.
        div_zero   = ~in_is_mult & (in_b == 32'd0);
        last_iter  = (cnt_q == LastCnt);
        // 0x80000000 negates to itself and is then read as unsigned 2^31.
        a_mag      = in_a[31] ? (~in_a + 32'd1) : in_a;
        b_mag      = in_b[31] ? (~in_b + 32'd1) : in_b;

        mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
        mul_next   = {mul_sum, acc_q[31:1]};
        prod       = sign_q ? (~mul_next + 64'd1) : mul_next;
        // Product fits in 32 signed bits only if bits [63:31] are a pure sign extension.
        mul_exc    = ~((&prod[63:31]) | ~(|prod[63:31]));

        // rem_q < divisor, so the shifted remainder minus the divisor fits 34 signed bits.
        rem_wide   = {rem_q, acc_q[31]};
        div_diff   = rem_wide - {2'b00, b_mag_q};
        div_ge     = ~div_diff[33];
        rem_next   = div_ge ? div_diff[32:0] : rem_wide[32:0];
        quo_next   = {acc_q[30:0], div_ge};
        quo_signed = sign_q ? (~quo_next + 32'd1) : quo_next;
        // Only a positive quotient of 2^31 (i.e. 0x80000000 / -1) is unrepresentable.
        div_exc    = ~sign_q & quo_next[31];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            a_mag_q       <= 32'd0;
            b_mag_q       <= 32'd0;
            sign_q        <= 1'b0;
            mult_q        <= 1'b0;
            ir_q          <= 32'd0;
            cnt_q         <= 6'd0;
            acc_q         <= 64'd0;
            rem_q         <= 33'd0;
            out_valid     <= 1'b0;
            out_result    <= 32'd0;
            out_exception <= 1'b0;
            out_ir        <= 32'd0;
            busy          <= 1'b0;
        end else if (flush) begin
            // Output data is left as is; out_valid low is enough to squash it.
            state_q   <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_mag_q <= a_mag;
                        b_mag_q <= b_mag;
                        sign_q  <= in_a[31] ^ in_b[31];
                        mult_q  <= in_is_mult;
                        ir_q    <= in_ir;
                        cnt_q   <= 6'd0;
                        acc_q   <= {32'd0, in_is_mult ? b_mag : a_mag};
                        rem_q   <= 33'd0;
                        busy    <= 1'b1;
                        if (div_zero) begin
                            state_q       <= StDone;
                            out_valid     <= 1'b1;
                            out_result    <= 32'd0;
                            out_exception <= 1'b1;
                            out_ir        <= in_ir;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (mult_q) begin
                        acc_q <= mul_next;
                    end else begin
                        acc_q <= {acc_q[63:32], quo_next};
                        rem_q <= rem_next;
                    end
                    cnt_q <= last_iter ? cnt_q : cnt_q + 6'd1;
                    if (last_iter) begin
                        state_q       <= StDone;
                        out_valid     <= 1'b1;
                        out_result    <= mult_q ? prod[31:0] : quo_signed;
                        out_exception <= mult_q ? mul_exc : div_exc;
                        out_ir        <= ir_q;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
